// File: rtl/md_pkg.sv
// ============================================================================
// Module      : md_pkg
// Description : Shared types for the MD force-pipeline / ring-node fabric.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam int RING_INJ_MAX_REQ = 8;

    typedef struct packed {
        logic [7:0]  dest_id;
        logic [23:0] payload;
    } packet_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ring_inj_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; searches from i_ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_any_grant
);

    logic [PTR_W-1:0] w_sel;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_sel       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sel = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_sel]) begin
                o_grant        = '0;
                o_grant[w_sel] = 1'b1;
                o_grant_idx    = w_sel;
                o_any_grant    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ring_inject_arbiter.sv
// ============================================================================
// Module      : ring_inject_arbiter
// Description : Round-robin share of one ring-node PE injection port among
//               NUM_REQ force pipelines, with a phase sequencing FSM.
//               Optional statistics ports under `RING_INJ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_inject_arbiter
    import md_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_phase_start,
    input  packet_t [NUM_REQ-1:0]     i_req_pkt,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ-1:0]        i_req_done,
    output packet_t                   o_ring_pkt,
    output logic                      o_ring_valid,
    input  logic                      i_ring_ready,
    output logic                      o_busy,
    output logic                      o_phase_done,
    output logic [CNT_W-1:0]          o_pkt_count
`ifdef RING_INJ_STATS_EN
    ,
    output logic [NUM_REQ-1:0][CNT_W-1:0] o_grant_count,
    output logic [CNT_W-1:0]              o_stall_cycles
`endif
);

    localparam int c_PTR_W = $clog2(NUM_REQ);

    ring_inj_state_t        r_state;
    ring_inj_state_t        w_state_next;
    logic [NUM_REQ-1:0]     r_buf_valid;
    packet_t [NUM_REQ-1:0]  r_buf;
    logic [NUM_REQ-1:0]     r_done_flag;
    logic [NUM_REQ-1:0]     w_done_flag_next;
    logic [NUM_REQ-1:0]     w_grant;
    logic [c_PTR_W-1:0]     w_grant_idx;
    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic                   w_any_grant;
    packet_t                r_ring_pkt;
    logic                   r_ring_valid;
    logic [CNT_W-1:0]       r_pkt_count;
    logic                   w_start;
    logic                   w_run;
    logic                   w_out_free;
    logic                   w_ring_xfer;

    assign w_start          = (r_state == IDLE) & i_phase_start;
    assign w_run            = (r_state == RUN);
    assign w_done_flag_next = r_done_flag | (w_run ? i_req_done : '0);
    assign w_out_free       = ~r_ring_valid | i_ring_ready;
    assign w_ring_xfer      = r_ring_valid & i_ring_ready;

    assign o_req_ready  = {NUM_REQ{w_run}} & ~r_buf_valid & ~r_done_flag;
    assign o_ring_pkt   = r_ring_pkt;
    assign o_ring_valid = r_ring_valid;
    assign o_pkt_count  = r_pkt_count;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_arbiter (
        .i_req       (r_buf_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_phase_start) w_state_next = RUN;
            RUN:     if (&w_done_flag_next) w_state_next = DRAIN;
            DRAIN:   if (~|r_buf_valid & ~r_ring_valid) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state == RUN) | (r_state == DRAIN);
        o_phase_done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_flag <= '0;
        end else if (w_start) begin
            r_done_flag <= '0;
        end else begin
            r_done_flag <= w_done_flag_next;
        end
    end

    // Skid buffers: a fill and a grant never hit the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_req_valid[i] & o_req_ready[i]) begin
                    r_buf_valid[i] <= 1'b1;
                end else if (w_out_free & w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i] & o_req_ready[i]) begin
                r_buf[i] <= i_req_pkt[i];
            end
        end
    end

    // Pointer parks on the last index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ring_valid <= 1'b0;
            r_ring_pkt   <= '0;
            r_rr_ptr     <= c_PTR_W'(NUM_REQ - 1);
        end else begin
            if (w_start) begin
                r_rr_ptr <= c_PTR_W'(NUM_REQ - 1);
            end
            if (w_out_free) begin
                if (w_any_grant) begin
                    r_ring_valid <= 1'b1;
                    r_ring_pkt   <= r_buf[w_grant_idx];
                    r_rr_ptr     <= w_grant_idx;
                end else begin
                    r_ring_valid <= 1'b0;
                    r_ring_pkt   <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count <= '0;
        end else if (w_start) begin
            r_pkt_count <= '0;
        end else if (w_ring_xfer && (r_pkt_count != '1)) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

`ifdef RING_INJ_STATS_EN
    logic [c_PTR_W-1:0]            r_out_src;
    logic [NUM_REQ-1:0][CNT_W-1:0] r_grant_count;
    logic [CNT_W-1:0]              r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_src <= '0;
        end else if (w_out_free & w_any_grant) begin
            r_out_src <= w_grant_idx;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                r_grant_count[g] <= '0;
            end else if (w_start) begin
                r_grant_count[g] <= '0;
            end else if (w_ring_xfer && (r_out_src == c_PTR_W'(g))
                         && (r_grant_count[g] != '1)) begin
                r_grant_count[g] <= r_grant_count[g] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_start) begin
            r_stall_cycles <= '0;
        end else if (r_ring_valid && !i_ring_ready && o_busy
                     && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_grant_count  = r_grant_count;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ring_inject_arbiter.sv
// ============================================================================
// Module      : tb_ring_inject_arbiter
// Description : Self-checking bench for ring_inject_arbiter with a queue-based
//               reference model. Exercises stats ports under RING_INJ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_inject_arbiter;
    import md_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 16;

    logic                  clk = 1'b0;
    logic                  i_rst;
    logic                  i_phase_start;
    packet_t [NUM_REQ-1:0] i_req_pkt;
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [NUM_REQ-1:0]    o_req_ready;
    logic [NUM_REQ-1:0]    i_req_done;
    packet_t               o_ring_pkt;
    logic                  o_ring_valid;
    logic                  i_ring_ready;
    logic                  o_busy;
    logic                  o_phase_done;
    logic [CNT_W-1:0]      o_pkt_count;
`ifdef RING_INJ_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] o_grant_count;
    logic [CNT_W-1:0]              o_stall_cycles;
`endif

    always #5 clk = ~clk;

    ring_inject_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (i_rst),
        .i_phase_start (i_phase_start),
        .i_req_pkt     (i_req_pkt),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_done    (i_req_done),
        .o_ring_pkt    (o_ring_pkt),
        .o_ring_valid  (o_ring_valid),
        .i_ring_ready  (i_ring_ready),
        .o_busy        (o_busy),
        .o_phase_done  (o_phase_done),
        .o_pkt_count   (o_pkt_count)
`ifdef RING_INJ_STATS_EN
        ,
        .o_grant_count (o_grant_count),
        .o_stall_cycles(o_stall_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: packets waiting to be offered, and packets accepted but not yet on the ring.
    packet_t send_q[NUM_REQ][$];
    packet_t exp_q[NUM_REQ][$];
    bit      done_pend[NUM_REQ];
    bit      done_with_last;
    bit      start_pending;
    int      valid_pct;
    int      ready_mode;
    int      stalls_left;
    int      xfer_cnt[NUM_REQ];
    int      total_xfer;
    int      grant_log[$];
    int      xfer_cyc[$];
    int      phase_done_cnt;
    int      stall_model;
    int      cyc;
    int      first_req_cyc;
    int      first_ring_cyc;
    bit      prev_hold;
    bit      prev_rv;
    packet_t prev_pkt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic packet_t mk(input int src, input int n);
        packet_t p;
        p.dest_id = 8'($urandom);
        p.payload = {4'(src), 20'(n)};
        return p;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            send_q[i].delete();
            exp_q[i].delete();
            done_pend[i] = 1'b0;
            xfer_cnt[i]  = 0;
        end
        total_xfer     = 0;
        grant_log.delete();
        xfer_cyc.delete();
        phase_done_cnt = 0;
        stall_model    = 0;
        stalls_left    = 0;
        first_req_cyc  = -1;
        first_ring_cyc = -1;
        prev_hold      = 1'b0;
        done_with_last = 1'b0;
    endtask

    task automatic tick();
        int src;
        @(posedge clk);
        #1;
        cyc++;
        i_phase_start = start_pending;
        start_pending = 1'b0;
        i_req_valid   = '0;
        i_req_done    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            i_req_pkt[i] = packet_t'($urandom);
            if (send_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                i_req_valid[i] = 1'b1;
                i_req_pkt[i]   = send_q[i][0];
            end
            if (done_pend[i] && (send_q[i].size() == 0 ||
                (done_with_last && send_q[i].size() == 1 && i_req_valid[i] && o_req_ready[i]))) begin
                i_req_done[i] = 1'b1;
                done_pend[i]  = 1'b0;
            end
        end
        case (ready_mode)
            0:       i_ring_ready = 1'b0;
            1:       i_ring_ready = 1'b1;
            default: i_ring_ready = 1'($urandom_range(1));
        endcase
        if (stalls_left > 0 && o_ring_valid) begin
            i_ring_ready = 1'b0;
            stalls_left--;
        end
        @(negedge clk);
        if (!i_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_req_valid[i] && o_req_ready[i]) begin
                    exp_q[i].push_back(send_q[i].pop_front());
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                end
            end
            if (o_ring_valid && first_ring_cyc < 0) first_ring_cyc = cyc;
            if (prev_hold) check("ring_hold", 64'(o_ring_pkt), 64'(prev_pkt));
            if (o_ring_valid && i_ring_ready) begin
                src = int'(o_ring_pkt.payload[23:20]);
                check("ring_src_has_pkt", 64'(src < NUM_REQ && exp_q[src].size() > 0), 64'd1);
                if (src < NUM_REQ && exp_q[src].size() > 0) begin
                    check("ring_order", 64'(o_ring_pkt), 64'(exp_q[src].pop_front()));
                    xfer_cnt[src]++;
                end
                grant_log.push_back(src);
                xfer_cyc.push_back(cyc);
                total_xfer++;
            end
            if (o_ring_valid && !i_ring_ready) stall_model++;
            if (o_phase_done) begin
                phase_done_cnt++;
                check("phase_done_after_ring_idle", 64'(prev_rv), 64'd0);
            end
            prev_hold = o_ring_valid && !i_ring_ready;
            prev_pkt  = o_ring_pkt;
            prev_rv   = o_ring_valid;
        end
    endtask

    task automatic start_phase();
        start_pending = 1'b1;
        tick();
        for (int i = 0; i < NUM_REQ; i++) done_pend[i] = 1'b1;
    endtask

    task automatic finish_phase(input string tag, input int budget);
        int n;
        int left;
        n = 0;
        while (phase_done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_phase_done_seen"}, 64'(phase_done_cnt), 64'd1);
        check({tag, "_pkt_count"}, 64'(o_pkt_count), 64'(total_xfer));
        tick();
        tick();
        check({tag, "_phase_done_single"}, 64'(phase_done_cnt), 64'd1);
        left = 0;
        for (int i = 0; i < NUM_REQ; i++) left += exp_q[i].size() + send_q[i].size();
        check({tag, "_all_delivered"}, 64'(left), 64'd0);
    endtask

    initial begin
        int base;
        cyc           = 0;
        i_rst         = 1'b1;
        i_phase_start = 1'b0;
        i_req_valid   = '0;
        i_req_done    = '0;
        i_req_pkt     = '0;
        i_ring_ready  = 1'b0;
        start_pending = 1'b0;
        valid_pct     = 100;
        ready_mode    = 1;
        prev_rv       = 1'b0;
        reset_model();
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check("rst_ring_valid", 64'(o_ring_valid), 64'd0);
        check("rst_ring_pkt", 64'(o_ring_pkt), 64'd0);
        check("rst_req_ready", 64'(o_req_ready), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_phase_done", 64'(o_phase_done), 64'd0);
        check("rst_pkt_count", 64'(o_pkt_count), 64'd0);

        // Single requester, three packets, latency 2.
        reset_model();
        for (int n = 0; n < 3; n++) send_q[0].push_back(mk(0, n));
        start_phase();
        finish_phase("single", 60);
        check("single_latency", 64'(first_ring_cyc - first_req_cyc), 64'd2);
        check("single_total", 64'(total_xfer), 64'd3);

        // All requesters continuously valid: strict rotation from requester 0.
        reset_model();
        for (int i = 0; i < NUM_REQ; i++)
            for (int n = 0; n < 4; n++) send_q[i].push_back(mk(i, n));
        start_phase();
        finish_phase("rr", 120);
        for (int k = 0; k < 16; k++) check("rr_grant_order", 64'(grant_log[k]), 64'(k % NUM_REQ));
        for (int i = 0; i < NUM_REQ; i++) check("rr_per_req", 64'(xfer_cnt[i]), 64'd4);
        check("rr_back_to_back", 64'(xfer_cyc[15] - xfer_cyc[0]), 64'd15);

        // Backpressure with output register plus all four buffers full.
        reset_model();
        send_q[0].push_back(mk(0, 0));
        send_q[0].push_back(mk(0, 1));
        for (int i = 1; i < NUM_REQ; i++) send_q[i].push_back(mk(i, 0));
        ready_mode = 0;
        start_phase();
        repeat (3) tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_req_ready", 64'(o_req_ready), 64'd0);
            check("bp_ring_valid", 64'(o_ring_valid), 64'd1);
        end
        ready_mode = 1;
        repeat (5) tick();
        check("bp_drain_count", 64'(total_xfer), 64'd5);
        check("bp_drain_consecutive", 64'(xfer_cyc[4] - xfer_cyc[0]), 64'd4);
        finish_phase("bp", 40);

        // Done in the same cycle as the last transfer.
        reset_model();
        for (int i = 0; i < NUM_REQ; i++) send_q[i].push_back(mk(i, 0));
        done_with_last = 1'b1;
        start_phase();
        tick();
        tick();
        check("dl_state_drain", 64'(dut.r_state), 64'(DRAIN));
        check("dl_busy", 64'(o_busy), 64'd1);
        finish_phase("dl", 60);
        check("dl_total", 64'(total_xfer), 64'(NUM_REQ));

        // Randomised phases.
        for (int r = 0; r < 4; r++) begin
            reset_model();
            base = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                int cnt;
                cnt = $urandom_range(8);
                for (int n = 0; n < cnt; n++) send_q[i].push_back(mk(i, n));
                base += cnt;
            end
            valid_pct      = 40 + $urandom_range(50);
            ready_mode     = 2;
            done_with_last = 1'($urandom_range(1));
            start_phase();
            finish_phase("rand", 2000);
            check("rand_total", 64'(total_xfer), 64'(base));
        end
        valid_pct  = 100;
        ready_mode = 1;

        // Reset in the middle of DRAIN with two buffers occupied.
        reset_model();
        for (int i = 0; i < 3; i++) send_q[i].push_back(mk(i, 0));
        done_with_last = 1'b1;
        ready_mode     = 0;
        start_phase();
        repeat (3) tick();
        check("mr_pre_ring_valid", 64'(o_ring_valid), 64'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mr_ring_valid", 64'(o_ring_valid), 64'd0);
        check("mr_busy", 64'(o_busy), 64'd0);
        check("mr_pkt_count", 64'(o_pkt_count), 64'd0);
        reset_model();
        ready_mode = 1;
        repeat (4) tick();
        check("mr_no_phase_done", 64'(phase_done_cnt), 64'd0);
        send_q[3].push_back(mk(3, 0));
        start_phase();
        tick();
        check("mr_restart_busy", 64'(o_busy), 64'd1);
        finish_phase("mr", 60);
        check("mr_restart_total", 64'(total_xfer), 64'd1);

`ifdef RING_INJ_STATS_EN
        // Statistics: 2 + 5 packets with three forced stall cycles.
        reset_model();
        for (int n = 0; n < 2; n++) send_q[0].push_back(mk(0, n));
        for (int n = 0; n < 5; n++) send_q[2].push_back(mk(2, n));
        stalls_left = 3;
        start_phase();
        finish_phase("st", 80);
        check("st_grant0", 64'(o_grant_count[0]), 64'd2);
        check("st_grant1", 64'(o_grant_count[1]), 64'd0);
        check("st_grant2", 64'(o_grant_count[2]), 64'd5);
        check("st_grant3", 64'(o_grant_count[3]), 64'd0);
        check("st_stall_model", 64'(stall_model), 64'd3);
        check("st_stall_cycles", 64'(o_stall_cycles), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ring_inject_arbiter.md
# ring_inject_arbiter

Shares one ring-node PE injection port among NUM_REQ short-range force pipelines of a home cell, using round-robin arbitration. Each pipeline gets a one-entry skid buffer, and the output register holds a packet until the ring node raises pe_ready. A small phase FSM sequences one force-evaluation phase: it opens the requesters on phase_start, waits for every requester's done, drains all buffered packets and pulses phase_done. The block sits between the force pipelines and the ring node's pe_pkt_in/pe_pkt_valid/pe_ready port.

## Interface
- NUM_REQ, 4, number of force pipelines (requesters), 2..8
- CNT_W, 16, width of the injected-packet counter
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- phase_start  in  1  one-cycle pulse that opens a phase
- req_pkt  in  NUM_REQ x packet_t  packet from requester i
- req_valid  in  NUM_REQ  requester i presents a packet
- req_ready  out  NUM_REQ  buffer i can accept; reset 0
- req_done  in  NUM_REQ  one-cycle pulse: requester i has no more packets this phase
- ring_pkt  out  packet_t  to ring node pe_pkt_in; reset 0
- ring_valid  out  1  to ring node pe_pkt_valid; reset 0
- ring_ready  in  1  from ring node pe_ready
- busy  out  1  state is RUN or DRAIN; reset 0
- phase_done  out  1  one-cycle pulse at phase completion; reset 0
- pkt_count  out  CNT_W  packets injected this phase; reset 0

## Operation
- Phase FSM states and transitions:
  - IDLE goes to RUN on phase_start. On that edge, pkt_count, the done flags and the RR pointer (to requester 0) are cleared.
  - RUN goes to DRAIN when all sticky done flags are set, including flags set on the same edge.
  - DRAIN goes to DONE when every buffer is empty and ring_valid=0.
  - DONE asserts phase_done for one cycle, then returns to IDLE.
  - phase_start outside IDLE is ignored.
- Requester side:
  - req_ready[i] = (state==RUN) & ~buf_valid[i] & ~done_flag[i]. The value is combinational from registers.
  - A transfer happens when req_valid[i] & req_ready[i]; the packet is written into buf[i].
  - req_done[i] sets done_flag[i]. A transfer and req_done in the same cycle are both honoured.
  - req_done outside RUN is ignored.
- Output side:
  - The output register loads when (~ring_valid | ring_ready) and at least one buffer is valid.
  - The granted buffer is the first valid buffer in round-robin order, starting at rr_ptr+1 modulo NUM_REQ.
  - On the same edge, the granted buffer is cleared and rr_ptr takes the grant index.
  - When no buffer is valid and ring_ready=1, ring_valid drops to 0 and ring_pkt goes to 0.
- While ring_valid=1, ring_pkt stays stable until ring_ready=1.
- A ring transfer is ring_valid & ring_ready. It increments pkt_count, which saturates at all-ones.
- Packets are never dropped or reordered within one requester. Packet dest_id is not inspected.

## Timing
- Minimum latency is 2 cycles: req transfer at cycle t gives ring_valid=1 at t+2.
- Per-requester throughput is 1 packet per 2 cycles; aggregate throughput is 1 packet per cycle when ring_ready stays high.
- Round-robin fairness: with all NUM_REQ buffers continuously valid, each requester is granted exactly once in every NUM_REQ consecutive grants.
- ring_ready=0 with ring_valid=1: the output holds, and no buffer is granted.
- phase_done fires at the earliest 1 cycle after the last ring transfer.
- rst at any time takes effect on the next edge: all buffers empty, state IDLE, all outputs at their reset values. An in-flight packet is discarded.

## Configuration
- RING_INJ_STATS_EN defined:
  - Adds output grant_count, NUM_REQ x CNT_W: per-requester ring-transfer counts.
  - The counts are cleared on phase_start from IDLE and on rst, and saturate.
  - Adds output stall_cycles, CNT_W: cycles with ring_valid=1 & ring_ready=0 while busy.
- RING_INJ_STATS_EN undefined: neither port nor its logic exists. All other behaviour is identical.

## Structure
- md_pkg:
  - Supplies packet_t.
  - Gains ring_inj_state_t, an enum of IDLE, RUN, DRAIN and DONE.
  - Gains the constant RING_INJ_MAX_REQ = 8.
- Sub-module rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs are a request vector and the pointer. Outputs are a one-hot grant, the grant index and any_grant.
  - Purely combinational. The pointer register lives in ring_inject_arbiter.

## Test plan
- Single requester: phase_start, req0 sends 3 packets, ring_ready=1, then req_done to all 4 requesters.
  - Expect ring packets in order, the first 2 cycles after the transfer, pkt_count=3, and one phase_done pulse.
- All 4 requesters continuously valid, ring_ready=1:
  - Expect grant order 0,1,2,3,0,1,… (first after reset/phase_start is requester 0).
  - After 16 transfers each requester has 4, and ring_valid stays 1 every cycle once filled.
- ring_ready held 0 for 10 cycles with all buffers full:
  - Expect ring_pkt stable and all req_ready=0.
  - On release, 5 transfers drain in 5 consecutive cycles: the output register plus 4 buffers.
- req_done in the same cycle as the last transfer on all requesters:
  - Expect state DRAIN on the next cycle, and phase_done only after ring_valid falls.
  - Expect pkt_count equal to the total number of packets sent.
- rst mid-DRAIN with 2 buffers full:
  - Expect ring_valid=0, busy=0 and pkt_count=0 next cycle.
  - Expect no phase_done, and a new phase_start to be accepted.
- With RING_INJ_STATS_EN: requester 0 sends 2 packets and requester 2 sends 5, with 3 ring_ready stall cycles.
  - Expect grant_count={0:2,1:0,2:5,3:0} and stall_cycles=3.
